// File: rtl/cla_pkg.sv
// Shared definitions for the nibble-serial carry-look-ahead datapath.
package cla_pkg;

   localparam int NIBBLE_W = 4;

   typedef enum logic [1:0] {IDLE, RUN, DONE} seq_state_t;

endpackage

// File: rtl/cla_nibble_sequencer.sv
// Slices a wide addition into 4-bit nibbles, feeds them LSB-first through an
// external pipelined CLA4CLKd, and reassembles sum, carry-out and overflow.
module cla_nibble_sequencer
   import cla_pkg::*;
#(
   parameter int NIBBLES = 4,
   parameter int CLA_LAT = 2
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [NIBBLE_W*NIBBLES-1:0] a,
   input  logic [NIBBLE_W*NIBBLES-1:0] b,
   input  logic                        cin,
   output logic [NIBBLE_W-1:0]         cla_a,
   output logic [NIBBLE_W-1:0]         cla_b,
   output logic                        cla_c,
   input  logic [NIBBLE_W-1:0]         cla_s,
   input  logic                        cla_cout,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [NIBBLE_W*NIBBLES-1:0] sum,
   output logic                        cout,
   output logic                        ovf
);

   localparam int W       = NIBBLE_W * NIBBLES;
   localparam int NIB_CW  = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam int WAIT_CW = (CLA_LAT > 1) ? $clog2(CLA_LAT) : 1;
   localparam logic [NIB_CW-1:0]  LAST_NIB  = NIB_CW'(NIBBLES - 1);
   localparam logic [WAIT_CW-1:0] WAIT_LOAD = WAIT_CW'(CLA_LAT - 1);

   seq_state_t          state, state_nxt;
   logic [NIB_CW-1:0]   nib_idx;
   logic [WAIT_CW-1:0]  wait_cnt;
   logic [W-1:0]        a_sh, b_sh;
   logic                a_msb, b_msb;
   logic                accept, capture, last_nib;

   assign accept   = (state == IDLE) && in_valid;
   assign capture  = (state == RUN) && (wait_cnt == '0);
   assign last_nib = (nib_idx == LAST_NIB);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid) state_nxt = RUN;
         RUN:     if (capture && last_nib) state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == DONE);
   end

   // Nibble issue and result capture: cla_c doubles as the chained carry.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         nib_idx  <= '0;
         wait_cnt <= '0;
         cla_a    <= '0;
         cla_b    <= '0;
         cla_c    <= 1'b0;
         sum      <= '0;
         cout     <= 1'b0;
         ovf      <= 1'b0;
      end else if (accept) begin
         nib_idx  <= '0;
         wait_cnt <= WAIT_LOAD;
         cla_a    <= a[NIBBLE_W-1:0];
         cla_b    <= b[NIBBLE_W-1:0];
         cla_c    <= cin;
      end else if (state == RUN) begin
         if (!capture) begin
            wait_cnt <= wait_cnt - WAIT_CW'(1);
         end else begin
            sum[NIBBLE_W*nib_idx +: NIBBLE_W] <= cla_s;
            if (last_nib) begin
               cout <= cla_cout;
               ovf  <= (a_msb == b_msb) && (cla_s[NIBBLE_W-1] != a_msb);
            end else begin
               nib_idx  <= nib_idx + NIB_CW'(1);
               wait_cnt <= WAIT_LOAD;
               cla_a    <= a_sh[NIBBLE_W-1:0];
               cla_b    <= b_sh[NIBBLE_W-1:0];
               cla_c    <= cla_cout;
            end
         end
      end
   end

   // Operand shadow: the remaining nibbles, consumed from the bottom.
   always_ff @(posedge clk) begin
      if (accept) begin
         a_sh  <= a >> NIBBLE_W;
         b_sh  <= b >> NIBBLE_W;
         a_msb <= a[W-1];
         b_msb <= b[W-1];
      end else if (capture && !last_nib) begin
         a_sh <= a_sh >> NIBBLE_W;
         b_sh <= b_sh >> NIBBLE_W;
      end
   end

endmodule
